// File: rtl/if_id_fetch_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID decoupling queue.
//   Fetch side : if_valid, if_pc, if_instr  -> queue ;  Freeze  <- queue
//   Decode side: id_ready                   -> queue ;  id_valid, id_pc, id_instr <- queue
// The slave modport is the queue's view; master is the fetch/decode environment's view.
interface if_id_fetch_queue_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               if_valid;
    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               Freeze;
    logic               id_ready;
    logic               id_valid;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;

    modport master (
        output if_valid, if_pc, if_instr, id_ready,
        input  Freeze, id_valid, id_pc, id_instr
    );

    modport slave (
        input  if_valid, if_pc, if_instr, id_ready,
        output Freeze, id_valid, id_pc, id_instr
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// Decoupling instruction queue between fetch and decode.
// Holds up to DEPTH (PC, instruction) pairs and presents the oldest to decode.
// A taken branch flushes every stored entry and bumps a saturating flush counter.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   Br_taken    flush request; overrides push and pop in the same cycle
//   bus         fetch/decode handshake bundle (slave view)
//   count       occupancy, 0..DEPTH
//   flush_count flushes since reset, saturating at all-ones
module if_id_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 32,
    parameter int INSTR_W  = 32,
    parameter int FLUSH_CW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Br_taken,
    if_id_fetch_queue_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [FLUSH_CW-1:0]      flush_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INSTR_W;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.if_valid & ~full  & ~Br_taken;
    assign pop   = ~empty & bus.id_ready & ~Br_taken;

    // Outputs come only from registered state: no if_* -> id_* path, and
    // Freeze is a pure function of the registered count.
    assign bus.Freeze   = full;
    assign bus.id_valid = ~empty;
    assign {bus.id_pc, bus.id_instr} = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            flush_count <= '0;
        end else if (Br_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (flush_count != '1) begin
                flush_count <= flush_count + FLUSH_CW'(1);
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.if_pc, bus.if_instr};
        end
    end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_if_id_fetch_queue;
    localparam int DEPTH    = 4;
    localparam int PC_W     = 32;
    localparam int INSTR_W  = 32;
    localparam int FLUSH_CW = 2;
    localparam int FC_MAX   = (1 << FLUSH_CW) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  Br_taken = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic [FLUSH_CW-1:0]   flush_count;

    if_id_fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    if_id_fetch_queue #(
        .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .FLUSH_CW(FLUSH_CW)
    ) dut (
        .clk(clk), .rst(rst), .Br_taken(Br_taken), .bus(bus),
        .count(count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: list of stored {pc, instr}, oldest first.
    logic [63:0] q[$];
    int          fc = 0;
    logic [31:0] next_pc;
    logic [31:0] next_instr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'd0;
        chk("id_valid",    64'(bus.id_valid),  64'(q.size() != 0));
        chk("id_pc",       64'(bus.id_pc),     64'(head[63:32]));
        chk("id_instr",    64'(bus.id_instr),  64'(head[31:0]));
        chk("count",       64'(count),         64'(q.size()));
        chk("Freeze",      64'(bus.Freeze),    64'(q.size() == DEPTH));
        chk("flush_count", 64'(flush_count),   64'(fc));
    endtask

    // One clock: check current outputs, drive inputs, advance model with the edge.
    // Fetch only advances its PC when the instruction was actually accepted.
    task automatic step(input logic v, input logic rdy, input logic br);
        logic do_push;
        logic do_pop;
        check_outputs();
        bus.if_valid = v;
        bus.if_pc    = next_pc;
        bus.if_instr = next_instr;
        bus.id_ready = rdy;
        Br_taken     = br;
        do_push = !br && v && (q.size() < DEPTH);
        do_pop  = !br && rdy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (br) begin
            q.delete();
            fc = (fc < FC_MAX) ? fc + 1 : FC_MAX;
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({next_pc, next_instr});
        end
        if (do_push) begin
            next_pc    = next_pc + 32'd4;
            next_instr = $urandom;
        end
        Br_taken     = 1'b0;
        bus.if_valid = 1'b0;
        bus.id_ready = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; reset is observed asynchronously.
    task automatic do_reset();
        Br_taken     = 1'b0;
        bus.if_valid = 1'b0;
        bus.id_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_count",    64'(count),        64'd0);
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_Freeze",   64'(bus.Freeze),   64'd0);
        chk("rst_id_pc",    64'(bus.id_pc),    64'd0);
        chk("rst_id_instr", 64'(bus.id_instr), 64'd0);
        chk("rst_flush",    64'(flush_count),  64'd0);
        q.delete();
        fc = 0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_seq;
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_instr = '0;
        bus.id_ready = 1'b0;
        next_pc    = 32'h04;
        next_instr = $urandom;
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-stream with three entries held.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd3);
        do_reset();

        // Fill to DEPTH with decode stalled; fifth fetch is refused.
        next_pc = 32'h04;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        chk("fill_count",  64'(count),      64'd4);
        chk("fill_Freeze", 64'(bus.Freeze), 64'd1);
        chk("fill_head",   64'(bus.id_pc),  64'h04);
        chk("fill_held",   64'(next_pc),    64'h14);

        // Drain in order across pointer wrap while fetch keeps streaming.
        exp_seq = 32'h04;
        for (int i = 0; i < 12; i++) begin
            if (bus.id_valid) begin
                chk("drain_order", 64'(bus.id_pc), 64'(exp_seq));
                exp_seq = exp_seq + 32'd4;
            end
            step(1'b1, 1'b1, 1'b0);
        end

        // Steady push+pop at occupancy 2.
        do_reset();
        next_pc = 32'h200;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("steady_count", 64'(count), 64'd2);
            step(1'b1, 1'b1, 1'b0);
        end
        chk("steady_count_end", 64'(count), 64'd2);

        // Flush at occupancy 3 overrides simultaneous push and pop.
        do_reset();
        next_pc = 32'h40;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("preflush_count", 64'(count), 64'd3);
        step(1'b1, 1'b1, 1'b1);
        chk("flush_count0", 64'(count),        64'd0);
        chk("flush_valid",  64'(bus.id_valid), 64'd0);
        chk("flush_num",    64'(flush_count),  64'd1);
        chk("flush_Freeze", 64'(bus.Freeze),   64'd0);
        next_pc = 32'h104;
        step(1'b1, 1'b0, 1'b0);
        chk("target_pc",    64'(bus.id_pc),    64'h104);
        chk("target_valid", 64'(bus.id_valid), 64'd1);

        // Flush counter saturation over consecutive flushes.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (i >= 2) chk("flush_sat", 64'(flush_count), 64'd3);
        end

        // Flush while full drops Freeze the next cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        chk("full_Freeze", 64'(bus.Freeze), 64'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("full_flush_Freeze", 64'(bus.Freeze), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0);
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
